// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error monitor.
//   mon_state_t : monitor FSM states
//   DEF_WIDTH   : default operand width
//   abs_err()   : signed error (exact - apx) and its magnitude. It works at a fixed
//                 wide width, and callers slice the result down to their own product width.
package approx_mult_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int MAX_PROD_W = 32;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic signed [MAX_PROD_W:0] err;
    logic [MAX_PROD_W-1:0]      mag;
  } err_res_t;

  function automatic err_res_t abs_err(input logic [MAX_PROD_W-1:0] exact,
                                       input logic [MAX_PROD_W-1:0] apx);
    err_res_t r;
    r.err = $signed({1'b0, exact}) - $signed({1'b0, apx});
    r.mag = r.err[MAX_PROD_W] ? MAX_PROD_W'(-r.err) : r.err[MAX_PROD_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/approx_err_datapath.sv
// Two-stage error pipeline with no handshake.
//   S1 registers the exact product x*y and z_apx.
//   S2 registers the signed error, the magnitude and the error flag.
// Ports: clk/rst (async active-high), flush (drops in-flight valids), accept (load S1),
//        x/y/z_apx sample, v1/v2 stage valids, err/mag/neq S2 results.
module approx_err_datapath
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    accept,
  input  logic [WIDTH-1:0]        x,
  input  logic [WIDTH-1:0]        y,
  input  logic [2*WIDTH-1:0]      z_apx,
  output logic                    v1,
  output logic                    v2,
  output logic signed [2*WIDTH:0] err,
  output logic [2*WIDTH-1:0]      mag,
  output logic                    neq
);

  logic [2*WIDTH-1:0] exact_q;
  logic [2*WIDTH-1:0] apx_q;
  err_res_t           res;
  logic               unused_mag_hi;

  always_comb res = abs_err(MAX_PROD_W'(exact_q), MAX_PROD_W'(apx_q));

  // The upper magnitude bits are always zero, because |err| fits in 2*WIDTH bits.
  assign unused_mag_hi = |res.mag[MAX_PROD_W-1:2*WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      exact_q <= '0;
      apx_q   <= '0;
      err     <= '0;
      mag     <= '0;
      neq     <= 1'b0;
    end else begin
      v1 <= accept & ~flush;
      v2 <= v1 & ~flush;
      if (accept) begin
        exact_q <= {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        apx_q   <= z_apx;
      end
      if (v1) begin
        err <= res.err[2*WIDTH:0];
        mag <= res.mag[2*WIDTH-1:0];
        neq <= (res.err != '0);
      end
    end
  end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Collects per-window error statistics for an approximate WIDTHxWIDTH multiplier.
// Ports: clk, rst (async active-high), clear (abort the current window),
//        in_valid/in_ready with x, y, z_apx for the sample stream,
//        out_valid/out_ready with sum_abs, sum_err, max_abs, err_cnt for the window report.
// state  | meaning
// ACCUM  | accepting samples until WINDOW have been taken
// DRAIN  | no new samples; waits for the pipeline and the accumulate step to empty
// REPORT | statistics are held on the outputs until out_ready
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = 256,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              x,
  input  logic [WIDTH-1:0]              y,
  input  logic [2*WIDTH-1:0]            z_apx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH+CNT_W-1:0]      sum_abs,
  output logic signed [2*WIDTH+CNT_W:0] sum_err,
  output logic [2*WIDTH-1:0]            max_abs,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WINDOW - 1);

  mon_state_t                  state_q, state_d;
  logic                        rdy_q;
  logic                        accept;
  logic                        v1, v2, neq;
  logic signed [PW:0]          err;
  logic [PW-1:0]               mag;
  logic                        latch_out, rpt_done, zero_acc;
  logic [CNT_W-1:0]            smp_cnt;
  logic [PW+CNT_W-1:0]         sum_abs_acc;
  logic signed [PW+CNT_W:0]    sum_err_acc;
  logic [PW-1:0]               max_abs_acc;
  logic [CNT_W-1:0]            err_cnt_acc;

  // rdy_q keeps in_ready low while rst is asserted, even though the state is ACCUM.
  assign in_ready  = rdy_q & (state_q == ACCUM) & ~clear;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == REPORT);

  approx_err_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .flush  (clear),
    .accept (accept),
    .x      (x),
    .y      (y),
    .z_apx  (z_apx),
    .v1     (v1),
    .v2     (v2),
    .err    (err),
    .mag    (mag),
    .neq    (neq)
  );

  always_comb begin
    state_d   = state_q;
    latch_out = 1'b0;
    rpt_done  = 1'b0;
    case (state_q)
      ACCUM:  if (accept && smp_cnt == LAST_SMP) state_d = DRAIN;
      DRAIN:  if (!v1 && !v2) begin
                state_d   = REPORT;
                latch_out = 1'b1;
              end
      REPORT: if (out_ready) begin
                state_d  = ACCUM;
                rpt_done = 1'b1;
              end
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d   = ACCUM;
      latch_out = 1'b0;
      rpt_done  = 1'b0;
    end
    zero_acc = clear | rpt_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt     <= '0;
      sum_abs_acc <= '0;
      sum_err_acc <= '0;
      max_abs_acc <= '0;
      err_cnt_acc <= '0;
      sum_abs     <= '0;
      sum_err     <= '0;
      max_abs     <= '0;
      err_cnt     <= '0;
    end else if (zero_acc) begin
      smp_cnt     <= '0;
      sum_abs_acc <= '0;
      sum_err_acc <= '0;
      max_abs_acc <= '0;
      err_cnt_acc <= '0;
      if (clear) begin
        sum_abs <= '0;
        sum_err <= '0;
        max_abs <= '0;
        err_cnt <= '0;
      end
    end else begin
      if (accept) smp_cnt <= smp_cnt + CNT_W'(1);
      if (v2) begin
        sum_abs_acc <= sum_abs_acc + {{CNT_W{1'b0}}, mag};
        sum_err_acc <= sum_err_acc + {{CNT_W{err[PW]}}, err};
        if (mag > max_abs_acc) max_abs_acc <= mag;
        err_cnt_acc <= err_cnt_acc + CNT_W'(neq);
      end
      if (latch_out) begin
        sum_abs <= sum_abs_acc;
        sum_err <= sum_err_acc;
        max_abs <= max_abs_acc;
        err_cnt <= err_cnt_acc;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
module tb_approx_mult_err_monitor;

  localparam int W   = 8;
  localparam int WA  = 4;
  localparam int WB  = 256;
  localparam int CWA = $clog2(WA + 1);
  localparam int CWB = $clog2(WB + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                      clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [W-1:0]              x_a, y_a;
  logic [2*W-1:0]            z_a, max_abs_a;
  logic [2*W+CWA-1:0]        sum_abs_a;
  logic signed [2*W+CWA:0]   sum_err_a;
  logic [CWA-1:0]            err_cnt_a;

  logic                      clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [W-1:0]              x_b, y_b;
  logic [2*W-1:0]            z_b, max_abs_b;
  logic [2*W+CWB-1:0]        sum_abs_b;
  logic signed [2*W+CWB:0]   sum_err_b;
  logic [CWB-1:0]            err_cnt_b;

  approx_mult_err_monitor #(.WIDTH(W), .WINDOW(WA)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x(x_a), .y(y_a), .z_apx(z_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sum_abs(sum_abs_a), .sum_err(sum_err_a), .max_abs(max_abs_a), .err_cnt(err_cnt_a)
  );

  approx_mult_err_monitor #(.WIDTH(W), .WINDOW(WB)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x(x_b), .y(y_b), .z_apx(z_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sum_abs(sum_abs_b), .sum_err(sum_err_b), .max_abs(max_abs_b), .err_cnt(err_cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: window statistics computed directly from the accepted samples.
  longint m_sabs, m_serr, m_max, m_cnt;

  task automatic model_clear();
    m_sabs = 0; m_serr = 0; m_max = 0; m_cnt = 0;
  endtask

  task automatic model_add(input int xx, input int yy, input int zz);
    longint e, a;
    e = longint'(xx) * longint'(yy) - longint'(zz);
    a = (e < 0) ? -e : e;
    m_sabs += a;
    m_serr += e;
    if (a > m_max) m_max = a;
    if (e != 0) m_cnt++;
  endtask

  task automatic rand_sample(input int mode, output int xx, output int yy, output int zz);
    int p;
    xx = int'($urandom_range(0, 255));
    yy = int'($urandom_range(0, 255));
    p  = xx * yy;
    case (mode)
      0: zz = p;
      1: begin
        zz = p + int'($urandom_range(0, 8)) - 4;
        if (zz < 0) zz = 0;
        if (zz > 65535) zz = 65535;
      end
      default: zz = int'($urandom_range(0, 65535));
    endcase
  endtask

  // Presents one sample after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_a(input int xx, input int yy, input int zz, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      x_a = W'($urandom);
      y_a = W'($urandom);
      z_a = 16'($urandom);
    end
    @(negedge clk);
    in_valid_a = 1'b1;
    x_a = W'(xx);
    y_a = W'(yy);
    z_a = 16'(zz);
    n = 0;
    #1;
    while (!in_ready_a && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready_a) chk("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      model_add(xx, yy, zz);
    end
  endtask

  // Called right after the last accepting edge: checks DRAIN and the report latency, then the stats.
  task automatic reach_report_a(input string tag);
    int lat;
    #1;
    chk({tag, "_drain_rdy"}, longint'(in_ready_a), 0);
    lat = 0;
    while (!out_valid_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_sum_abs"}, longint'(sum_abs_a), m_sabs);
    chk({tag, "_sum_err"}, longint'(sum_err_a), m_serr);
    chk({tag, "_max_abs"}, longint'(max_abs_a), m_max);
    chk({tag, "_err_cnt"}, longint'(err_cnt_a), m_cnt);
  endtask

  // Holds the report for 'hold' cycles with in_valid noise, then completes the handshake.
  task automatic handshake_a(input string tag, input int hold);
    repeat (hold) begin
      @(negedge clk);
      in_valid_a = 1'($urandom);
      x_a = W'($urandom);
      y_a = W'($urandom);
      z_a = 16'($urandom);
      #1;
      chk({tag, "_hold_ready"}, longint'(in_ready_a), 0);
      chk({tag, "_hold_valid"}, longint'(out_valid_a), 1);
      chk({tag, "_hold_abs"}, longint'(sum_abs_a), m_sabs);
      chk({tag, "_hold_err"}, longint'(sum_err_a), m_serr);
    end
    @(negedge clk);
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_valid"}, longint'(out_valid_a), 0);
    chk({tag, "_done_ready"}, longint'(in_ready_a), 1);
    @(negedge clk);
    out_ready_a = 1'b0;
    model_clear();
  endtask

  task automatic rand_window_a(input string tag, input int hold);
    int xx, yy, zz;
    for (int i = 0; i < WA; i++) begin
      rand_sample(int'($urandom_range(0, 2)), xx, yy, zz);
      send_a(xx, yy, zz, int'($urandom_range(0, 2)));
    end
    reach_report_a(tag);
    handshake_a(tag, hold);
  endtask

  initial begin
    int xx, yy, zz, cyc, acc;
    longint eb;
    clear_a = 0; in_valid_a = 0; out_ready_a = 0; x_a = 0; y_a = 0; z_a = 0;
    clear_b = 0; in_valid_b = 0; out_ready_b = 0; x_b = 0; y_b = 0; z_b = 0;
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_a", longint'(in_ready_a), 0);
    chk("rst_in_ready_b", longint'(in_ready_b), 0);
    chk("rst_out_valid", longint'(out_valid_a), 0);
    chk("rst_sum_abs", longint'(sum_abs_a), 0);
    chk("rst_err_cnt", longint'(err_cnt_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", longint'(in_ready_a), 1);

    // Exact products, back to back apart from one gap
    send_a(3, 5, 15, 0);
    send_a(255, 255, 65025, 0);
    send_a(0, 7, 0, 1);
    send_a(16, 16, 256, 0);
    reach_report_a("exact");
    handshake_a("exact", 0);

    // Injected errors, followed by backpressure for 10 cycles
    send_a(3, 5, 14, 0);
    send_a(3, 5, 16, 0);
    send_a(10, 10, 96, 0);
    send_a(2, 2, 4, 0);
    reach_report_a("inj");
    handshake_a("inj", 10);

    // The next window must start from zeroed accumulators
    rand_window_a("after_bp", 1);

    // Tied maxima
    send_a(2, 2, 0, 0);
    send_a(4, 1, 0, 0);
    send_a(1, 1, 5, 0);
    send_a(3, 3, 5, 0);
    reach_report_a("tie");
    handshake_a("tie", 0);

    // Clear after 2 samples, then 4 exact samples
    for (int i = 0; i < 2; i++) begin
      rand_sample(2, xx, yy, zz);
      send_a(xx, yy, zz, 0);
    end
    @(negedge clk);
    clear_a = 1'b1;
    in_valid_a = 1'b1;
    #1;
    chk("clr_ready", longint'(in_ready_a), 0);
    @(negedge clk);
    clear_a = 1'b0;
    in_valid_a = 1'b0;
    model_clear();
    for (int i = 0; i < WA; i++) begin
      rand_sample(0, xx, yy, zz);
      send_a(xx, yy, zz, 0);
    end
    reach_report_a("clr");
    handshake_a("clr", 0);

    // When clear and out_ready arrive together in REPORT, clear wins
    for (int i = 0; i < WA; i++) begin
      rand_sample(1, xx, yy, zz);
      send_a(xx, yy, zz, 0);
    end
    reach_report_a("clr_rep");
    @(negedge clk);
    in_valid_a = 1'b0;
    clear_a = 1'b1;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_rep_valid", longint'(out_valid_a), 0);
    @(negedge clk);
    clear_a = 1'b0;
    out_ready_a = 1'b0;
    model_clear();
    rand_window_a("after_clr", 2);

    // Randomized windows
    for (int w = 0; w < 15; w++) rand_window_a("rnd", int'($urandom_range(0, 3)));

    // Make the held report nonzero, then assert an asynchronous reset during DRAIN
    for (int i = 0; i < WA; i++) begin
      rand_sample(2, xx, yy, zz);
      send_a(xx, yy, zz, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", longint'(out_valid_a), 0);
    chk("arst_in_ready", longint'(in_ready_a), 0);
    chk("arst_sum_abs", longint'(sum_abs_a), 0);
    chk("arst_max_abs", longint'(max_abs_a), 0);
    chk("arst_err_cnt", longint'(err_cnt_a), 0);
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    rand_window_a("post_arst", 0);

    // Worst case on the full-size window: every sample gives the largest possible error
    eb = 0;
    @(negedge clk);
    in_valid_b = 1'b1;
    x_b = 8'd255;
    y_b = 8'd255;
    z_b = 16'd0;
    acc = 0;
    cyc = 0;
    while (acc < WB && cyc < 400) begin
      #1;
      if (in_ready_b) begin
        acc++;
        eb += longint'(255) * 255;
      end
      cyc++;
      if (acc < WB) @(negedge clk);
    end
    chk("wc_accepts", acc, WB);
    @(negedge clk);
    in_valid_b = 1'b0;
    cyc = 0;
    #1;
    while (!out_valid_b && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("wc_valid", longint'(out_valid_b), 1);
    chk("wc_sum_abs", longint'(sum_abs_b), eb);
    chk("wc_sum_err", longint'(sum_err_b), eb);
    chk("wc_max_abs", longint'(max_abs_b), 65025);
    chk("wc_err_cnt", longint'(err_cnt_b), WB);
    @(negedge clk);
    out_ready_b = 1'b1;
    @(posedge clk);
    #1;
    chk("wc_done_ready", longint'(in_ready_b), 1);
    @(negedge clk);
    out_ready_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
